// File: rtl/dot_dash_tx.sv
// Mark/space serial transmitter: dot = 1 high cycle, dash = DASH_LEN, then GAP_LEN low.
// Define DOT_DASH_TX_DONE_EN to add a registered done pulse per completed symbol.
module dot_dash_tx #(
  parameter int DASH_LEN = 3,
  parameter int GAP_LEN  = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic valid,
  input  logic sym,
  output logic ready,
  output logic O,
`ifdef DOT_DASH_TX_DONE_EN
  output logic done,
`endif
  output logic busy
);

  localparam int MAXL = (DASH_LEN > GAP_LEN) ? DASH_LEN : GAP_LEN;
  localparam int CW   = $clog2(MAXL) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            o_q;
  logic            busy_q;
  logic            accept;
  logic            last;
  logic [CW-1:0]   mark_len;

  assign last     = (cnt_q == CW'(1));
  assign ready    = !RESET &&
                    ((state_q == IDLE) ||
                     ((state_q == SPACE) && last));
  assign accept   = valid && ready;
  assign mark_len = sym ? CW'(DASH_LEN) : CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MARK;
          cnt_d   = mark_len;
        end
      end
      MARK: begin
        if (last) begin
          state_d = SPACE;
          cnt_d   = CW'(GAP_LEN);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SPACE: begin
        if (last) begin
          // Reload in the last gap cycle so back-to-back marks keep the gap exact.
          if (accept) begin
            state_d = MARK;
            cnt_d   = mark_len;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= (state_d == MARK);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign O    = o_q;
  assign busy = busy_q;

`ifdef DOT_DASH_TX_DONE_EN
  logic done_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == SPACE) && (cnt_d == CW'(1));
    end
  end

  assign done = done_q;
`endif

endmodule
